// File: rtl/byte_logic_sched.sv
// Two-requester round-robin scheduler in front of one shared byte-wide logic unit.
// A granted operation is latched, evaluated one cycle later and held as a tagged result until taken.
module byte_logic_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R0_valid,
  output logic             R0_ready,
  input  logic [1:0]       R0_op,
  input  logic [7:0]       R0_A,
  input  logic [7:0]       R0_B,
  input  logic             R1_valid,
  output logic             R1_ready,
  input  logic [1:0]       R1_op,
  input  logic [7:0]       R1_A,
  input  logic [7:0]       R1_B,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [7:0]       Res_data,
  output logic             Res_id,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1,
  output logic             Busy,
  output logic [1:0]       dbg_state_o,
  output logic             dbg_prio_o
);

  // Handshakes: a request moves on Rx_valid && Rx_ready, a result on Res_valid && Res_ready;
  // Rx_ready is only ever high in IDLE and only for the granted requester.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             prio_q;
  logic             id_q;
  logic [1:0]       op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             res_valid_q;
  logic [7:0]       res_data_q;
  logic             res_id_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic             grant_v_d;
  logic             grant_id_d;
  logic [7:0]       alu_d;

  always_comb begin
    grant_v_d  = (state_q == IDLE) && (R0_valid || R1_valid);
    grant_id_d = R1_valid;
    if (R0_valid && R1_valid) begin
      grant_id_d = prio_q;
    end
  end

  assign R0_ready = grant_v_d && !grant_id_d;
  assign R1_ready = grant_v_d && grant_id_d;

  always_comb begin
    alu_d = 8'h00;
    case (op_q)
      2'b00:   alu_d = a_q | b_q;
      2'b01:   alu_d = a_q & b_q;
      2'b10:   alu_d = a_q ^ b_q;
      default: alu_d = ~(a_q | b_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_id_q    <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_v_d) begin
            id_q    <= grant_id_d;
            op_q    <= grant_id_d ? R1_op : R0_op;
            a_q     <= grant_id_d ? R1_A : R0_A;
            b_q     <= grant_id_d ? R1_B : R0_B;
            prio_q  <= ~grant_id_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= alu_d;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Result and tag stay frozen until the consumer takes them.
          if (Res_ready) begin
            res_valid_q <= 1'b0;
            if (res_id_q) begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Res_valid   = res_valid_q;
  assign Res_data    = res_data_q;
  assign Res_id      = res_id_q;
  assign Cnt0        = cnt0_q;
  assign Cnt1        = cnt1_q;
  assign Busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_byte_logic_sched.sv
// Directed bench for byte_logic_sched: a default-width instance and a CNT_W=2 instance share all inputs.
module tb_byte_logic_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       R0_valid, R1_valid, Res_ready;
  logic [1:0] R0_op, R1_op;
  logic [7:0] R0_A, R0_B, R1_A, R1_B;

  logic       R0_ready, R1_ready, Res_valid, Res_id, Busy, dbg_prio;
  logic [7:0] Res_data, Cnt0, Cnt1;
  logic [1:0] dbg_state;

  logic       d2_r0_ready, d2_r1_ready, d2_res_valid, d2_res_id, d2_busy, d2_prio;
  logic [7:0] d2_res_data;
  logic [1:0] d2_cnt0, d2_cnt1, d2_state;

  always #5 clk = ~clk;

  byte_logic_sched #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .R0_valid(R0_valid), .R0_ready(R0_ready), .R0_op(R0_op), .R0_A(R0_A), .R0_B(R0_B),
    .R1_valid(R1_valid), .R1_ready(R1_ready), .R1_op(R1_op), .R1_A(R1_A), .R1_B(R1_B),
    .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_data(Res_data), .Res_id(Res_id),
    .Cnt0(Cnt0), .Cnt1(Cnt1), .Busy(Busy), .dbg_state_o(dbg_state), .dbg_prio_o(dbg_prio)
  );

  byte_logic_sched #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .R0_valid(R0_valid), .R0_ready(d2_r0_ready), .R0_op(R0_op), .R0_A(R0_A), .R0_B(R0_B),
    .R1_valid(R1_valid), .R1_ready(d2_r1_ready), .R1_op(R1_op), .R1_A(R1_A), .R1_B(R1_B),
    .Res_valid(d2_res_valid), .Res_ready(Res_ready), .Res_data(d2_res_data), .Res_id(d2_res_id),
    .Cnt0(d2_cnt0), .Cnt1(d2_cnt1), .Busy(d2_busy), .dbg_state_o(d2_state), .dbg_prio_o(d2_prio)
  );

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[9];
  logic [8:0] exp_q[$];
  logic [7:0] cnt_exp[2];
  logic [1:0] cnt2_exp[2];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    R0_valid = 1'b0;
    R1_valid = 1'b0;
    Res_ready = 1'b0;
    tick();
    rst = 1'b0;
    cnt_exp[0] = 8'd0;
    cnt_exp[1] = 8'd0;
    cnt2_exp[0] = 2'd0;
    cnt2_exp[1] = 2'd0;
    exp_q.delete();
  endtask

  task automatic check_result(input string tag);
    logic [8:0] e;
    chk({tag, "_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, Res_data, e[7:0]);
      chk({tag, "_id"}, Res_id, e[8]);
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_prio"}, dbg_prio, 0);
    chk({tag, "_res_valid"}, Res_valid, 0);
    chk({tag, "_res_data"}, Res_data, 0);
    chk({tag, "_res_id"}, Res_id, 0);
    chk({tag, "_cnt0"}, Cnt0, 0);
    chk({tag, "_cnt1"}, Cnt1, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_d2_state"}, d2_state, 0);
    chk({tag, "_d2_prio"}, d2_prio, 0);
    chk({tag, "_d2_res_valid"}, d2_res_valid, 0);
  endtask

  // Issue one operation with Res_ready=1 and check the fixed 2-cycle latency and the count update.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
    if (id) begin
      R1_valid = 1'b1; R1_op = op; R1_A = a; R1_B = b;
    end else begin
      R0_valid = 1'b1; R0_op = op; R0_A = a; R0_B = b;
    end
    Res_ready = 1'b1;
    #1;
    chk("ready_granted", id ? R1_ready : R0_ready, 1);
    chk("ready_other", id ? R0_ready : R1_ready, 0);
    chk("d2_ready_granted", id ? d2_r1_ready : d2_r0_ready, 1);
    exp_q.push_back({id, exp});
    tick();
    R0_valid = 1'b0;
    R1_valid = 1'b0;
    R0_op = ~op; R0_A = ~a; R0_B = ~b;
    R1_op = ~op; R1_A = ~a; R1_B = ~b;
    #1;
    chk("busy_exec", Busy, 1);
    chk("d2_busy_exec", d2_busy, 1);
    chk("res_valid_exec", Res_valid, 0);
    tick();
    chk("res_valid_done", Res_valid, 1);
    chk("d2_res_valid_done", d2_res_valid, 1);
    chk("d2_res_data", d2_res_data, exp);
    chk("d2_res_id", d2_res_id, id);
    check_result("op_result");
    tick();
    cnt_exp[id]++;
    cnt2_exp[id]++;
    chk("busy_after", Busy, 0);
    chk("res_valid_after", Res_valid, 0);
    chk("cnt0", Cnt0, cnt_exp[0]);
    chk("cnt1", Cnt1, cnt_exp[1]);
    chk("d2_cnt0", d2_cnt0, cnt2_exp[0]);
    chk("d2_cnt1", d2_cnt1, cnt2_exp[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wrap_seq[5];
    int         ngr;
    int         c1;

    vecs[0] = '{1'b0, 2'b00, 8'hA5, 8'h5A, 8'hFF};
    vecs[1] = '{1'b1, 2'b00, 8'hF0, 8'h3C, 8'hFC};
    vecs[2] = '{1'b1, 2'b01, 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{1'b1, 2'b10, 8'hF0, 8'h3C, 8'hCC};
    vecs[4] = '{1'b1, 2'b11, 8'hF0, 8'h3C, 8'h03};
    vecs[5] = '{1'b0, 2'b01, 8'hFF, 8'h0F, 8'h0F};
    vecs[6] = '{1'b0, 2'b10, 8'hAA, 8'hFF, 8'h55};
    vecs[7] = '{1'b0, 2'b11, 8'hFF, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 2'b11, 8'h00, 8'h00, 8'hFF};
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    R0_op = 2'b00; R0_A = 8'h00; R0_B = 8'h00;
    R1_op = 2'b00; R1_A = 8'h00; R1_B = 8'h00;
    do_reset();
    check_idle_after_reset("reset");

    // Single ops and opcode sweep.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      if (i == 4) chk("cnt1_after_sweep", Cnt1, 4);
    end

    // Continuous dual requests after reset: grants alternate 0,1,0,1 three cycles apart.
    do_reset();
    R0_valid = 1'b1; R0_op = 2'b00; R0_A = 8'h01; R0_B = 8'h02;
    R1_valid = 1'b1; R1_op = 2'b01; R1_A = 8'hFF; R1_B = 8'h81;
    Res_ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("no_dual_ready", R0_ready && R1_ready, 0);
      if (c % 3 == 0) begin
        chk("rr_grant_r0", R0_ready, (ngr % 2 == 0));
        chk("rr_grant_r1", R1_ready, (ngr % 2 == 1));
        exp_q.push_back((ngr % 2 == 0) ? 9'h003 : 9'h181);
        ngr++;
      end else begin
        chk("rr_no_grant_mid", R0_ready || R1_ready, 0);
      end
      if (c % 3 == 2) begin
        chk("rr_res_valid", Res_valid, 1);
        check_result("rr_result");
      end
      tick();
    end
    R0_valid = 1'b0;
    R1_valid = 1'b0;
    chk("rr_cnt0", Cnt0, 2);
    chk("rr_cnt1", Cnt1, 2);
    cnt_exp[0] = 8'd2;
    cnt_exp[1] = 8'd2;

    // Backpressure: result held for 10 cycles while another request waits.
    R1_valid = 1'b1; R1_op = 2'b10; R1_A = 8'h12; R1_B = 8'h34;
    Res_ready = 1'b0;
    #1;
    chk("bp_accept", R1_ready, 1);
    tick();
    R1_valid = 1'b0;
    R0_valid = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_res_valid", Res_valid, 1);
      chk("bp_res_data", Res_data, 8'h26);
      chk("bp_res_id", Res_id, 1);
      chk("bp_no_ready", R0_ready || R1_ready, 0);
      chk("bp_cnt1", Cnt1, cnt_exp[1]);
      chk("bp_state", dbg_state, 2);
      tick();
    end
    R0_valid = 1'b0;
    Res_ready = 1'b1;
    tick();
    chk("bp_release_state", dbg_state, 0);
    chk("bp_release_valid", Res_valid, 0);
    chk("bp_release_cnt1", Cnt1, cnt_exp[1] + 8'd1);
    chk("bp_release_cnt0", Cnt0, cnt_exp[0]);

    // Reset during EXEC, then during DONE; both discard the operation.
    R0_valid = 1'b1; R0_op = 2'b00; R0_A = 8'h11; R0_B = 8'h22;
    tick();
    R0_valid = 1'b0;
    chk("rst_exec_pre_state", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_after_reset("rst_exec");
    R0_valid = 1'b1;
    Res_ready = 1'b0;
    tick();
    R0_valid = 1'b0;
    tick();
    chk("rst_done_pre_valid", Res_valid, 1);
    chk("rst_done_pre_prio", dbg_prio, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_after_reset("rst_done");
    R0_valid = 1'b1;
    R1_valid = 1'b1;
    #1;
    chk("post_rst_grant_r0", R0_ready, 1);
    chk("post_rst_grant_r1", R1_ready, 0);
    R0_valid = 1'b0;
    R1_valid = 1'b0;

    // Counter wrap on the CNT_W=2 instance.
    do_reset();
    c1 = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, vecs[c1].op, vecs[c1].a, vecs[c1].b, vecs[c1].exp);
      chk("wrap_cnt0", d2_cnt0, wrap_seq[i]);
      chk("wrap_cnt1", d2_cnt1, 0);
      c1 = (c1 == 0) ? 5 : ((c1 == 7) ? 0 : c1 + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
